// File: rtl/pwm_button_cond_if.sv
// pwm_button_cond_if: button inputs, enable and conditioned duty pulses/levels
interface pwm_button_cond_if;
    logic en;
    logic btn_up;
    logic btn_dn;
    logic duty_inc;
    logic duty_dec;
    logic btn_up_db;
    logic btn_dn_db;

    modport master (
        output en, btn_up, btn_dn,
        input  duty_inc, duty_dec, btn_up_db, btn_dn_db
    );

    modport slave (
        input  en, btn_up, btn_dn,
        output duty_inc, duty_dec, btn_up_db, btn_dn_db
    );
endinterface

// File: rtl/pwm_button_cond.sv
// pwm_button_cond: synchronize and debounce up/down buttons, emit single-cycle duty pulses with hold-to-repeat
module pwm_button_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 32,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    pwm_button_cond_if.slave  bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] UP_HELD = 3'd1;
    localparam logic [2:0] UP_RPT  = 3'd2;
    localparam logic [2:0] DN_HELD = 3'd3;
    localparam logic [2:0] DN_RPT  = 3'd4;
    localparam logic [2:0] LOCK    = 3'd5;

    // bit 0 is the up button, bit 1 the down button
    logic [1:0]            meta_q, meta_d;
    logic [1:0]            sync_q, sync_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            prev_q, prev_d;
    logic [1:0]            arm_q, arm_d;
    logic [1:0]            vld_q, vld_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            st_q, st_d;
    logic [CNT_W-1:0]      t_q, t_d;
    logic                  inc_q, inc_d;
    logic                  dec_q, dec_d;
    logic [1:0]            rise;
    logic [CNT_W-1:0]      lim;
    logic                  up, dn;

    assign up   = db_q[0];
    assign dn   = db_q[1];
    // a button held through reset stays disarmed until it has been seen released
    assign rise = db_q & ~prev_q & arm_q;
    assign lim  = (st_q == UP_HELD || st_q == DN_HELD) ? CNT_W'(HOLD_CYCLES - 1)
                                                       : CNT_W'(REPEAT_CYCLES - 1);

    // synchronizer, debounce counters and release-arming per button
    always_comb begin
        meta_d = {bus.btn_dn, bus.btn_up};
        sync_d = meta_q;
        vld_d  = {vld_q[0], 1'b1};
        prev_d = db_q;
        arm_d  = arm_q | (vld_q[1] ? ~(sync_q | db_q) : 2'b00);
        db_d   = db_q;
        cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    db_d[i] = sync_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // press / hold / repeat FSM shared by both buttons; release wins over timer expiry
    always_comb begin
        st_d  = st_q;
        t_d   = '0;
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (!bus.en) begin
            st_d = IDLE;
        end else begin
            case (st_q)
                IDLE: begin
                    if ((rise[0] && dn) || (rise[1] && up)) begin
                        st_d = LOCK;
                    end else if (rise[0]) begin
                        inc_d = 1'b1;
                        st_d  = UP_HELD;
                    end else if (rise[1]) begin
                        dec_d = 1'b1;
                        st_d  = DN_HELD;
                    end
                end
                UP_HELD, UP_RPT: begin
                    if (!up) begin
                        st_d = IDLE;
                    end else if (dn) begin
                        st_d = LOCK;
                    end else if (t_q == lim) begin
                        inc_d = 1'b1;
                        st_d  = UP_RPT;
                    end else begin
                        t_d = t_q + CNT_W'(1);
                    end
                end
                DN_HELD, DN_RPT: begin
                    if (!dn) begin
                        st_d = IDLE;
                    end else if (up) begin
                        st_d = LOCK;
                    end else if (t_q == lim) begin
                        dec_d = 1'b1;
                        st_d  = DN_RPT;
                    end else begin
                        t_d = t_q + CNT_W'(1);
                    end
                end
                LOCK: begin
                    st_d = (!up && !dn) ? IDLE : LOCK;
                end
                default: begin
                    st_d = IDLE;
                end
            endcase
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            st_q   <= IDLE;
            t_q    <= '0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            db_q   <= db_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            t_q    <= t_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
        end
    end

    assign bus.duty_inc  = inc_q;
    assign bus.duty_dec  = dec_q;
    assign bus.btn_up_db = db_q[0];
    assign bus.btn_dn_db = db_q[1];
endmodule
